// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// A PC register drives instruction memory directly. Fetched words are captured
// with their byte address into a two-entry FIFO whose head is presented downstream.
// Redirects flush the FIFO and restart fetch. A misaligned redirect sets a sticky
// fault that freezes fetch until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault
);

  logic [31:0] pc;
  logic [31:0] head_pc;
  logic [31:0] head_word;
  logic [31:0] tail_pc;
  logic [31:0] tail_word;
  logic [1:0]  count;
  logic        valid_q;
  logic        fault_q;

  logic        pop;
  logic        push;
  logic        redirect;

  // Handshake decode: redirect outranks push/pop and is ignored once faulted
  always_comb begin
    pop      = valid_q & instr_ready;
    redirect = redirect_valid & ~fault_q;
    push     = ~fault_q & ~redirect_valid & ((count != 2'd2) | pop);
  end

  // PC, FIFO and fault state; the head entry is the registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      count     <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      head_pc   <= '0;
      head_word <= '0;
      tail_pc   <= '0;
      tail_word <= '0;
    end else if (redirect) begin
      count   <= '0;
      valid_q <= 1'b0;
      pc      <= {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        fault_q <= 1'b1;
      end
    end else begin
      if (push) begin
        pc <= pc + 32'd4;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc   <= pc;
            head_word <= imem_rdata;
          end else begin
            tail_pc   <= pc;
            tail_word <= imem_rdata;
          end
          count   <= count + 2'd1;
          valid_q <= 1'b1;
        end
        2'b01: begin
          head_pc   <= tail_pc;
          head_word <= tail_word;
          count     <= count - 2'd1;
          valid_q   <= (count == 2'd2);
        end
        2'b11: begin
          // Occupancy unchanged; the tail advances to head so order is kept
          if (count == 2'd1) begin
            head_pc   <= pc;
            head_word <= imem_rdata;
          end else begin
            head_pc   <= tail_pc;
            head_word <= tail_word;
            tail_pc   <= pc;
            tail_word <= imem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign instr_valid = valid_q;
  assign instr       = head_word;
  assign instr_pc    = head_pc;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a queue-based reference model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] MAIN_PC = 32'h00000000;
  localparam logic [31:0] WRAP_PC = 32'hFFFFFFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT signals
  logic        rst, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
  logic        instr_valid, fault;

  // wrap DUT signals
  logic        w_rst = 1'b1;
  logic [31:0] w_addr, w_rdata, w_instr, w_instr_pc;
  logic        w_valid, w_fault;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  fetch_unit #(.RESET_PC(MAIN_PC)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .fault(fault)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(w_rst), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_valid), .instr_ready(1'b1),
    .instr(w_instr), .instr_pc(w_instr_pc), .fault(w_fault)
  );

  // Reference model: fetch address, sticky fault, queue of {pc, word}
  logic [31:0] m_pc = MAIN_PC;
  logic        m_fault = 1'b0;
  logic [63:0] m_q[$];
  logic [97:0] obs, exp_v;

  function automatic logic [97:0] model_vec();
    logic [63:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 64'h0;
    return {m_q.size() != 0, m_fault, m_pc, h};
  endfunction

  function automatic logic [97:0] dut_vec();
    return {instr_valid, fault, imem_addr,
            instr_valid ? instr_pc : 32'h0, instr_valid ? instr : 32'h0};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return at negedge
  task automatic tick(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    int  n;
    logic pop;
    rst = r; redirect_valid = rv; redirect_pc = rp; instr_ready = rdy;
    @(posedge clk);
    n   = m_q.size();
    pop = (n != 0) && rdy;
    if (r) begin
      m_pc = MAIN_PC; m_fault = 1'b0; m_q.delete();
    end else if (rv && !m_fault) begin
      m_q.delete();
      if (rp[1:0] != 2'b00) m_fault = 1'b1;
      m_pc = {rp[31:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_fault && !rv && (n < 2 || pop)) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    checks++;
    if ({instr_valid, fault, imem_addr, instr_pc, instr} !== {1'b0, 1'b0, MAIN_PC, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b f=%b addr=%h pc=%h w=%h, want all zero", instr_valid, fault, imem_addr, instr_pc, instr);
    end
  endtask

  task automatic test_straight_line();
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i)}) begin
        errors++;
        $display("FAIL straight_line[%0d]: got v=%b pc=%h w=%h, want pc=%h", i, instr_valid, instr_pc, instr, i * 4);
      end
      obs = dut_vec(); exp_v = model_vec(); checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL straight_model[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_backpressure();
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      obs = dut_vec(); exp_v = model_vec(); checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
    checks++;
    if ({imem_addr, instr_pc} !== {32'h8, 32'h0}) begin
      errors++;
      $display("FAIL backpressure_stall: got addr=%h pc=%h want addr=00000008 pc=00000000", imem_addr, instr_pc);
    end
    // first release cycle pops pc 0 and leaves pc 4 at head
    for (int i = 1; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if ({instr_valid, instr_pc} !== {1'b1, 32'(i * 4)}) begin
        errors++;
        $display("FAIL backpressure_release[%0d]: got v=%b pc=%h want pc=%h", i, instr_valid, instr_pc, i * 4);
      end
    end
  endtask

  task automatic test_redirect();
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'h40, 1'b1);
    checks++;
    if ({instr_valid, imem_addr} !== {1'b0, 32'h40}) begin
      errors++;
      $display("FAIL redirect_flush: got v=%b addr=%h want v=0 addr=00000040", instr_valid, imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h40, mem_word(32'h40)}) begin
      errors++;
      $display("FAIL redirect_first: got v=%b pc=%h w=%h want pc=00000040", instr_valid, instr_pc, instr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h44}) begin
      errors++;
      $display("FAIL redirect_second: got v=%b pc=%h want pc=00000044", instr_valid, instr_pc);
    end
  endtask

  task automatic test_misaligned();
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h42, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, (i == 2), 32'h80, 1'b1);
      checks++;
      if ({fault, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h40}) begin
        errors++;
        $display("FAIL misaligned_freeze[%0d]: got f=%b v=%b addr=%h want f=1 v=0 addr=00000040", i, fault, instr_valid, imem_addr);
      end
    end
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({fault, imem_addr} !== {1'b0, MAIN_PC}) begin
      errors++;
      $display("FAIL misaligned_clear: got f=%b addr=%h want f=0 addr=%h", fault, imem_addr, MAIN_PC);
    end
  endtask

  task automatic test_reset_midstream();
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    checks++;
    if ({instr_valid, imem_addr, fault} !== {1'b0, MAIN_PC, 1'b0}) begin
      errors++;
      $display("FAIL reset_midstream: got v=%b addr=%h f=%b want v=0 addr=%h f=0", instr_valid, imem_addr, fault, MAIN_PC);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, MAIN_PC}) begin
      errors++;
      $display("FAIL reset_first_push: got v=%b pc=%h want v=1 pc=%h", instr_valid, instr_pc, MAIN_PC);
    end
  endtask

  task automatic test_random();
    logic r, rv, rdy;
    logic [31:0] rp;
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rp  = {20'h0, $urandom_range(0, 4095)} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      rdy = ($urandom_range(0, 3) != 0);
      tick(r, rv, rp, rdy);
      obs = dut_vec(); exp_v = model_vec(); checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seq [3];
    seq[0] = 32'hFFFF_FFF8; seq[1] = 32'hFFFF_FFFC; seq[2] = 32'h0000_0000;
    w_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({w_valid, w_addr} !== {1'b0, WRAP_PC}) begin
      errors++;
      $display("FAIL wrap_reset: got v=%b addr=%h want v=0 addr=%h", w_valid, w_addr, WRAP_PC);
    end
    w_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({w_valid, w_instr_pc, w_instr} !== {1'b1, seq[i], mem_word(seq[i])}) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: got v=%b pc=%h w=%h want pc=%h", i, w_valid, w_instr_pc, w_instr, seq[i]);
      end
    end
    checks++;
    if (w_addr !== 32'h4) begin
      errors++;
      $display("FAIL wrap_addr: got %h want 00000004", w_addr);
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_reset_midstream();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, byte address loaded into the PC on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_addr  output  32  byte address to instruction memory, word index = imem_addr[31:2].
REQ-005 imem_rdata  input  32  instruction word from memory, combinationally valid in the same cycle as imem_addr.
REQ-006 redirect_valid  input  1  single-cycle request to restart fetch at redirect_pc.
REQ-007 redirect_pc  input  32  new fetch byte address, sampled only when redirect_valid=1.
REQ-008 instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-009 instr_ready  input  1  downstream accepts the instruction this cycle.
REQ-010 instr  output  32  fetched instruction word.
REQ-011 instr_pc  output  32  byte address of instr.
REQ-012 fault  output  1  sticky misaligned-redirect flag.

Function
REQ-013 State: PC register (32 b), 2-entry FIFO of {pc, word}, 2-bit occupancy count, sticky fault bit.
REQ-014 imem_addr SHALL equal the PC register at all times, including stall and fault cycles.
REQ-015 Pop occurs when instr_valid=1 and instr_ready=1; instr, instr_pc and instr_valid come from the FIFO head, registered, with no combinational path from imem_rdata.
REQ-016 Push occurs when fault=0, redirect_valid=0, and either count<2 or a pop occurs in the same cycle.
REQ-017 A push writes {PC, imem_rdata} and advances PC by 4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-018 When no push occurs, PC and imem_addr SHALL hold their value.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-020 When full (count=2) with no pop, push SHALL be suppressed and no instruction SHALL be lost or duplicated.
REQ-021 Latency: a word pushed in cycle N SHALL appear on instr with instr_valid=1 in cycle N+1 if the FIFO was empty.
REQ-022 Sustained throughput with instr_ready held at 1 SHALL be one instruction per cycle.
REQ-023 Redirect with redirect_pc[1:0]=0 SHALL flush the FIFO (count to 0), load PC with redirect_pc, and perform no push that cycle.
REQ-024 Redirect has priority over push and pop; a handshake completing in the redirect cycle counts as consumed by downstream.
REQ-025 The first instruction from the redirect target SHALL appear with instr_valid=1 two cycles after the redirect cycle.
REQ-026 Redirect with redirect_pc[1:0]!=0 SHALL set fault=1 and flush the FIFO; PC SHALL take redirect_pc with bits [1:0] cleared.
REQ-027 While fault=1, pushes SHALL stop and subsequent redirects SHALL be ignored until reset.
REQ-028 instr_valid=0 SHALL be held whenever count=0.

Reset
REQ-029 rst=1 at a clock edge SHALL set PC=RESET_PC, count=0, fault=0, instr_valid=0, and instr=instr_pc=0.
REQ-030 Reset SHALL override push, pop and redirect in the same cycle, and SHALL discard any in-flight instructions mid-stream.
REQ-031 The first push SHALL occur in the first cycle with rst=0, so instr_valid=1 on the following cycle.

Verification
REQ-032 Straight-line: memory word k = 32'h1000_0000+k, instr_ready=1 -> instr_pc 0,4,8,... with matching words, one per cycle, no gaps after the first.
REQ-033 Backpressure: instr_ready=0 for 5 cycles -> count saturates at 2, imem_addr holds 8, instr_pc=0 stable; on release, instr_pc sequence 0,4,8,12 with no loss or duplication.
REQ-034 Redirect: redirect_valid=1, redirect_pc=32'h40 while 2 entries are queued -> FIFO flushed, instr_valid=0 the next cycle, then instr_pc=32'h40, then 32'h44.
REQ-035 Misaligned redirect: redirect_pc=32'h42 -> fault=1, instr_valid=0 thereafter, imem_addr=32'h40 frozen; a later redirect_pc=32'h80 is ignored; rst clears fault.
REQ-036 Wrap: RESET_PC=32'hFFFFFFF8 -> instr_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-037 Reset mid-stream: rst=1 with 2 entries queued and instr_ready=1 -> next cycle instr_valid=0, imem_addr=RESET_PC, fault=0.
